serial_add_ctrl: RTL

//   Bit-serial N-bit adder: sequences one adder_1bit cell over NUM_BITS cycles.

---
 rtl/serial_add_pkg.sv | 4 +
 rtl/adder_1bit.sv | 11 +
 rtl/serial_add_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, ADD, DONE} sa_state_t;
endpackage

// File: rtl/adder_1bit.sv
// Single full-adder cell, reused once per bit by the serial controller.
module adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial NUM_BITS adder: one full-adder cell walked LSB-first over NUM_BITS cycles,
// result and carry presented with a one-cycle done pulse.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int NUM_BITS = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                carry_in,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] sum,
   output logic                carry_out
);
   localparam int CW = $clog2(NUM_BITS);
   localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

   sa_state_t           state;
   logic [NUM_BITS-1:0] a_sr, b_sr, s_sr;
   logic                c_reg;
   logic [CW-1:0]       cnt;
   logic                sum_bit, cout;
   logic                accept;

   adder_1bit u_bit_add (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (c_reg),
      .s    (sum_bit),
      .cout (cout)
   );

   assign accept = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         s_sr      <= '0;
         c_reg     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ADD: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               s_sr  <= {sum_bit, s_sr[NUM_BITS-1:1]};
               c_reg <= cout;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum       <= {sum_bit, s_sr[NUM_BITS-1:1]};
                  carry_out <= cout;
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise
               done <= 1'b0;
               if (accept) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  c_reg <= carry_in;
                  cnt   <= '0;
                  state <= ADD;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst && accept)
         assert (!$isunknown({a, b, carry_in}))
            else $error("serial_add_ctrl: unknown operand at accepted start");
   end
endmodule
